// File: rtl/vec_cache_pre_alloc_multi.sv
// Multi-port free-entry pre-allocator: reserves the lowest free entry each cycle
// and queues its ID into the least-occupied enabled per-port FIFO.
module vec_cache_pre_alloc_multi #(
  parameter int ENTRY_NUM      = 32,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int OUT_PORT_NUM   = 2,
  parameter int PRE_ALLO_NUM   = 2,
  parameter int CNT_WIDTH      = $clog2(PRE_ALLO_NUM+1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ENTRY_NUM-1:0]                   v_in_vld,
  output logic [ENTRY_NUM-1:0]                   v_in_rdy,
  input  logic [OUT_PORT_NUM-1:0]                port_en,
  output logic [OUT_PORT_NUM-1:0]                out_vld,
  input  logic [OUT_PORT_NUM-1:0]                out_rdy,
  output logic [OUT_PORT_NUM*ENTRY_ID_WIDTH-1:0] out_index,
  output logic [OUT_PORT_NUM*CNT_WIDTH-1:0]      out_cnt
);

  localparam int PW  = (PRE_ALLO_NUM > 1) ? $clog2(PRE_ALLO_NUM) : 1;
  localparam int PIW = (OUT_PORT_NUM > 1) ? $clog2(OUT_PORT_NUM) : 1;
  localparam logic [PW-1:0]        PTR_LAST = PW'(PRE_ALLO_NUM-1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(PRE_ALLO_NUM);

  typedef logic [ENTRY_ID_WIDTH-1:0] id_t;
  typedef logic [PW-1:0]             ptr_t;
  typedef logic [CNT_WIDTH-1:0]      cnt_t;

  logic [ENTRY_NUM-1:0] rsv_q, rsv_d;
  cnt_t cnt_q [OUT_PORT_NUM];
  cnt_t cnt_d [OUT_PORT_NUM];
  ptr_t rd_q  [OUT_PORT_NUM];
  ptr_t rd_d  [OUT_PORT_NUM];
  ptr_t wr_q  [OUT_PORT_NUM];
  ptr_t wr_d  [OUT_PORT_NUM];
  id_t  mem_q [OUT_PORT_NUM][PRE_ALLO_NUM];
  id_t  mem_d [OUT_PORT_NUM][PRE_ALLO_NUM];

  logic [ENTRY_NUM-1:0] cand;
  logic                 cand_vld;
  id_t                  cand_id;
  logic                 tgt_vld;
  logic [PIW-1:0]       tgt_id;
  cnt_t                 tgt_cnt;
  logic                 fill;

  function automatic ptr_t nxt(input ptr_t v);
    return (v == PTR_LAST) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    cand     = v_in_vld & ~rsv_q;
    cand_vld = |cand;
    cand_id  = '0;
    for (int i = ENTRY_NUM-1; i >= 0; i--) begin
      if (cand[i]) cand_id = ENTRY_ID_WIDTH'(i);
    end
  end

  // Strict compare against the running minimum keeps ties on the lowest port.
  always_comb begin
    tgt_vld = 1'b0;
    tgt_id  = '0;
    tgt_cnt = CNT_FULL;
    for (int p = 0; p < OUT_PORT_NUM; p++) begin
      if (port_en[p] && cnt_q[p] < tgt_cnt) begin
        tgt_vld = 1'b1;
        tgt_id  = PIW'(p);
        tgt_cnt = cnt_q[p];
      end
    end
  end

  assign fill     = !rst && cand_vld && tgt_vld;
  assign v_in_rdy = fill ? ({{(ENTRY_NUM-1){1'b0}}, 1'b1} << cand_id) : '0;

  always_comb begin
    logic pop;
    logic push;
    rsv_d = rsv_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    mem_d = mem_q;
    for (int p = 0; p < OUT_PORT_NUM; p++) begin
      pop  = (cnt_q[p] != '0) && out_rdy[p];
      push = fill && (tgt_id == PIW'(p));
      if (pop) begin
        rsv_d[mem_q[p][rd_q[p]]] = 1'b0;
        rd_d[p] = nxt(rd_q[p]);
      end
      if (push) begin
        mem_d[p][wr_q[p]] = cand_id;
        wr_d[p] = nxt(wr_q[p]);
      end
      if (push && !pop) cnt_d[p] = cnt_q[p] + 1'b1;
      if (pop && !push) cnt_d[p] = cnt_q[p] - 1'b1;
    end
    if (fill) rsv_d[cand_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_q <= '0;
      cnt_q <= '{default: '0};
      rd_q  <= '{default: '0};
      wr_q  <= '{default: '0};
    end else begin
      rsv_q <= rsv_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    for (int p = 0; p < OUT_PORT_NUM; p++) begin
      out_vld[p] = (cnt_q[p] != '0);
      out_index[p*ENTRY_ID_WIDTH +: ENTRY_ID_WIDTH] =
        out_vld[p] ? mem_q[p][rd_q[p]] : '0;
      out_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
    end
  end

endmodule

// File: doc/vec_cache_pre_alloc_multi.md
# vec_cache_pre_alloc_multi

Multi-port free-entry pre-allocator for the vector cache data buffer. Each cycle it picks the lowest-index free entry from a free-entry vector, reserves it, and pushes its ID into one of several per-port pre-allocation FIFOs. Consumers such as MSHR or line-buffer allocators pop ready-made IDs with zero search latency. Unlike the single-port version, it:
- serves OUT_PORT_NUM consumers,
- masks IDs already held in any FIFO so no ID is handed out twice,
- balances fills across ports,
- supports per-port fill enable.

## Interface
Parameters:
- ENTRY_NUM, 32, number of allocatable entries
- ENTRY_ID_WIDTH, $clog2(ENTRY_NUM), entry ID width
- OUT_PORT_NUM, 2, number of consumer ports (1..8)
- PRE_ALLO_NUM, 2, FIFO depth per port (1..8)
- CNT_WIDTH, $clog2(PRE_ALLO_NUM+1), occupancy count width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- v_in_vld  in  ENTRY_NUM  bit i = entry i is free in the owner table
- v_in_rdy  out  ENTRY_NUM  one-hot grant; bit i = entry i is reserved this cycle
- port_en  in  OUT_PORT_NUM  per-port fill enable
- out_vld  out  OUT_PORT_NUM  port p has a buffered ID
- out_rdy  in  OUT_PORT_NUM  port p pops its head ID
- out_index  out  OUT_PORT_NUM*ENTRY_ID_WIDTH  head ID of port p at slice [p*ENTRY_ID_WIDTH +: ENTRY_ID_WIDTH]
- out_cnt  out  OUT_PORT_NUM*CNT_WIDTH  registered occupancy of port p

## Operation
- Reserved mask `rsv[ENTRY_NUM]` holds entries currently sitting in any FIFO.
  - Set bit on fill.
  - Clear bit on pop of that ID.
- Candidate vector = v_in_vld & ~rsv. A lead-one search selects the lowest set bit as the candidate ID.
- Target port: among ports with port_en=1 and registered out_cnt < PRE_ALLO_NUM, choose the one with the smallest out_cnt; ties go to the lowest port index.
- Fill occurs iff a candidate exists and a target exists.
  - v_in_rdy = candidate one-hot.
  - The ID is written to the target FIFO tail.
  - The rsv bit is set.
  - Otherwise v_in_rdy = 0.
- At most one fill per cycle across all ports.
- Pop on port p iff out_vld[p] && out_rdy[p]:
  - The head advances.
  - The rsv bit of the popped ID clears.
  - out_cnt[p] decrements.
- Simultaneous fill and pop on the same port: out_cnt unchanged, both take effect.
  - A full port is never a fill target, even if it pops that cycle, because selection uses registered counts.
- Simultaneous fill of ID x and pop of ID y (x != y, guaranteed by the mask): set x and clear y in the same cycle.
- Owner contract: once v_in_rdy[i]=1, v_in_vld[i] must stay 0 until the consumer frees entry i. A pop does not return the entry to the free pool.
- port_en=0 stops fills to that port only. Buffered IDs remain poppable.
- Each FIFO is a circular buffer with rd/wr pointers wrapping modulo PRE_ALLO_NUM, plus a count. Non-power-of-two depths wrap explicitly.
- out_index[p] is driven from the registered head. It is 0 when out_vld[p]=0.

## Timing
- Reset: all FIFOs empty, rsv=0, out_vld=0, out_index=0, out_cnt=0. v_in_rdy=0 for the whole reset cycle; no fill occurs while rst=1.
- Reset mid-operation discards all buffered IDs. The owner must resynchronise its free table.
- v_in_rdy is combinational from v_in_vld, rsv, port_en and registered counts. No combinational path from out_rdy.
- Fill latency: an ID granted in cycle T appears at out_index / out_vld in T+1 if the FIFO was empty.
- Pop in cycle T: the next head (or out_vld=0) is visible in T+1. The popped ID is candidate-eligible in T+1 if v_in_vld allows.
- Steady-state throughput: 1 ID/cycle aggregate fill; each port can pop 1 ID/cycle.

## Test plan
- Reset, then v_in_vld=32'hFFFF_FFFF, port_en=2'b11, out_rdy=0:
  - grants IDs 0,1,2,3 in cycles 0..3, alternating ports 0,1,0,1;
  - v_in_rdy=0 from cycle 4;
  - out_cnt = 2,2.
- v_in_vld held at 32'h0000_0008 (owner ignores the grant), out_rdy=0: ID 3 granted exactly once; no duplicate in either FIFO.
- Both FIFOs full, out_rdy=2'b01 with fresh free entries: port 0 pops 1/cycle. Each pop frees a slot refilled one cycle later. Port 1 receives nothing.
- port_en=2'b10 with free entries: only port 1 fills, up to PRE_ALLO_NUM. Port 0 drains its existing IDs, then out_vld[0]=0.
- Port 0 at count 1: fill and pop on port 0 in the same cycle; out_cnt[0] stays 1 and the head becomes the new ID.
- Assert rst mid-stream with both FIFOs full: the next cycle shows out_vld=0, out_cnt=0, rsv cleared. The first grant after release is the lowest free ID.
